// File: rtl/imem_loader_pkg.sv
// imem_loader shared types: frame parser states and framing constants.
// Imported by the loader top and its word-assembly sub-block.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    CKSUM,
    FIN
  } state_t;

  localparam logic [7:0] SYNC_DEF = 8'hA5;
  localparam int BPW = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream intake and imem write port of the instruction loader.
// master = byte source / imem side, slave = loader.
interface imem_loader_if #(
  parameter int AW = 6
);

  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          we;
  logic [AW-1:0] wa;
  logic [31:0]   wd;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, we, wa, wd
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, we, wa, wd
  );

endinterface

// File: rtl/imem_loader_asm.sv
// Big-endian byte-to-word assembler; word_valid marks the 4th byte
// in flight so the caller can register the write on that same edge.
module imem_loader_asm
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [23:0] sh;
  logic [1:0]  bcnt;

  assign word_valid = en && (bcnt == 2'(BPW - 1));
  assign word       = {sh, din};

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      sh   <= '0;
      bcnt <= '0;
    end else if (en) begin
      sh   <= {sh[15:0], din};
      bcnt <= bcnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream instruction-memory loader; holds the CPU during load.
// Define IMEM_LOADER_CKSUM_EN to require and verify a trailing XOR byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         AW   = 6,
  parameter logic [7:0] SYNC = SYNC_DEF
) (
  input  logic         clk,
  input  logic         reset,
  imem_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         done,
  output logic         err,
  output logic         busy
);

  state_t        state;
  logic [AW-1:0] cnt;
  logic [AW-1:0] widx;
  logic          acc;
  logic          wv;
  logic          last;
  logic [31:0]   word;

  assign bus.rx_ready = (state != FIN);
  assign acc          = bus.rx_valid && bus.rx_ready;
  // cnt of 0 wraps to all-ones here, giving a full 2**AW word frame
  assign last         = (widx == cnt - AW'(1));

  imem_loader_asm u_asm (
    .clk        (clk),
    .reset      (reset),
    .clr        (state == COUNT),
    .en         (acc && state == DATA),
    .din        (bus.rx_data),
    .word_valid (wv),
    .word       (word)
  );

`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0] cks;
  logic       ok;
  logic       err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cks   <= '0;
      ok    <= 1'b0;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (acc && state == COUNT)
        cks <= '0;
      else if (acc && state == DATA)
        cks <= cks ^ bus.rx_data;
      if (acc && state == CKSUM)
        ok <= (bus.rx_data == cks);
      if (state == FIN)
        err_q <= !ok;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      widx     <= '0;
      bus.we   <= 1'b0;
      bus.wa   <= '0;
      bus.wd   <= '0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      bus.we <= 1'b0;
      done   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (acc && bus.rx_data == SYNC) begin
            state    <= COUNT;
            cpu_hold <= 1'b1;
            busy     <= 1'b1;
          end
        end
        COUNT: begin
          if (acc) begin
            cnt   <= bus.rx_data[AW-1:0];
            widx  <= '0;
            state <= DATA;
          end
        end
        DATA: begin
          if (wv) begin
            bus.we <= 1'b1;
            bus.wa <= widx;
            bus.wd <= word;
            widx   <= widx + AW'(1);
`ifdef IMEM_LOADER_CKSUM_EN
            if (last) state <= CKSUM;
`else
            if (last) state <= FIN;
`endif
          end
        end
        CKSUM: begin
          if (acc) state <= FIN;
        end
        FIN: begin
          state    <= IDLE;
          cpu_hold <= 1'b0;
          busy     <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
          done     <= ok;
`else
          done     <= 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random frames
// compared cycle by cycle against a frame-level reference model.
module tb_imem_loader;

  localparam int AW = 6;
  localparam int DEPTH = 1 << AW;
  localparam logic [7:0] SYNC = 8'hA5;
`ifdef IMEM_LOADER_CKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic cpu_hold, done, err, busy;

  always #5 clk = ~clk;

  imem_loader_if #(.AW(AW)) bus ();

  imem_loader #(.AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err),
    .busy     (busy)
  );

  int total = 0;
  int bad = 0;

  logic [7:0]    s[$];
  logic [AW-1:0] wa_log[$];
  logic [31:0]   wd_log[$];
  int            done_n, err_n;

  // reference model: 0 hunt, 1 count, 2 payload, 3 checksum, 4 finishing
  int            ph;
  int            words_m, nb, widx_m;
  logic [7:0]    x_m;
  logic [31:0]   asm_w;
  bit            ok_m;
  logic          we_e, done_e, err_e, hold_e, ready_e;
  logic [AW-1:0] wa_e;
  logic [31:0]   wd_e;

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, o, e, $time);
    end
  endtask

  task automatic model_byte(input logic [7:0] d);
    case (ph)
      0: if (d == SYNC) begin
        ph = 1;
        hold_e = 1'b1;
      end
      1: begin
        words_m = (d % DEPTH == 0) ? DEPTH : d % DEPTH;
        nb = 0;
        x_m = 8'h00;
        widx_m = 0;
        ph = 2;
      end
      2: begin
        asm_w = {asm_w[23:0], d};
        nb++;
        x_m ^= d;
        if (nb % 4 == 0) begin
          we_e = 1'b1;
          wa_e = widx_m[AW-1:0];
          wd_e = asm_w;
          widx_m++;
          if (nb == 4 * words_m) ph = CK ? 3 : 4;
        end
      end
      3: begin
        ok_m = (d == x_m);
        ph = 4;
      end
      default: ;
    endcase
  endtask

  task automatic check_all();
    chk("we", bus.we, we_e);
    chk("wa", bus.wa, wa_e);
    chk("wd", bus.wd, wd_e);
    chk("done", done, done_e);
    chk("err", err, err_e);
    chk("cpu_hold", cpu_hold, hold_e);
    chk("busy", busy, hold_e);
    chk("rx_ready", bus.rx_ready, ready_e);
    if (bus.we === 1'b1) begin
      wa_log.push_back(bus.wa);
      wd_log.push_back(bus.wd);
    end
    if (done === 1'b1) done_n++;
    if (err === 1'b1) err_n++;
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit r,
                      output bit a);
    @(negedge clk);
    bus.rx_valid = v;
    bus.rx_data = d;
    reset = r;
    a = !r && v && ready_e;
    @(posedge clk);
    we_e = 1'b0;
    done_e = 1'b0;
    err_e = 1'b0;
    if (r) begin
      ph = 0;
      hold_e = 1'b0;
      wa_e = '0;
      wd_e = '0;
    end else if (ph == 4) begin
      ph = 0;
      hold_e = 1'b0;
      done_e = CK ? ok_m : 1'b1;
      err_e = CK && !ok_m;
    end else if (a) begin
      model_byte(d);
    end
    ready_e = (ph != 4);
    #1 check_all();
  endtask

  task automatic build(input int n, input logic [31:0] w[$],
                       input bit corrupt);
    logic [7:0] x = 8'h00;
    logic [7:0] b;
    s.push_back(SYNC);
    s.push_back(n[7:0]);
    foreach (w[i])
      for (int k = 3; k >= 0; k--) begin
        b = w[i][8*k +: 8];
        s.push_back(b);
        x ^= b;
      end
    if (CK) s.push_back(corrupt ? (x ^ 8'h01) : x);
  endtask

  // mode 0: valid every cycle, 1: every other cycle, 2: random
  task automatic run(input int mode);
    int i = 0;
    int n = 0;
    bit v, a;
    while (i < s.size() && n < 2000) begin
      case (mode)
        0: v = 1'b1;
        1: v = (n % 2 == 1);
        default: v = ($urandom_range(0, 1) == 1);
      endcase
      step(v, v ? s[i] : 8'($urandom), 1'b0, a);
      if (a) i++;
      n++;
    end
    s.delete();
    repeat (3) step(1'b0, 8'h00, 1'b0, a);
  endtask

  task automatic clear_logs();
    wa_log.delete();
    wd_log.delete();
    done_n = 0;
    err_n = 0;
  endtask

  initial begin
    logic [31:0] w[$];
    bit a;
    int n;
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    ph = 0;
    hold_e = 1'b0;
    ready_e = 1'b1;
    wa_e = '0;
    wd_e = '0;
    asm_w = '0;
    ok_m = 1'b0;
    clear_logs();

    step(1'b0, 8'h00, 1'b1, a);
    step(1'b0, 8'h00, 1'b1, a);

    // single word frame, continuous valid
    clear_logs();
    w = '{32'h12345678};
    build(1, w, 1'b0);
    run(0);
    chk("t1_nwr", wd_log.size(), 1);
    if (wd_log.size() > 0) chk("t1_wd", wd_log[0], 32'h12345678);
    chk("t1_done", done_n, 1);
    chk("t1_err", err_n, 0);

    // two words, good then corrupted checksum
    clear_logs();
    w = '{32'hDEADBEEF, 32'h00000001};
    build(2, w, 1'b0);
    build(2, w, 1'b1);
    run(0);
    chk("t2_nwr", wd_log.size(), 4);
    if (wd_log.size() == 4) begin
      chk("t2_wd0", wd_log[2], 32'hDEADBEEF);
      chk("t2_wa1", wa_log[3], 1);
    end
    chk("t2_done", done_n, CK ? 1 : 2);
    chk("t2_err", err_n, CK ? 1 : 0);

    // leading junk, valid toggling
    clear_logs();
    s.push_back(8'h00);
    s.push_back(8'hFF);
    w = '{32'hAABBCCDD};
    build(1, w, 1'b0);
    run(1);
    chk("t3_nwr", wd_log.size(), 1);
    if (wd_log.size() > 0) chk("t3_wd", wd_log[0], 32'hAABBCCDD);
    chk("t3_done", done_n, 1);

    // N=0 means full depth
    clear_logs();
    w.delete();
    for (int i = 0; i < DEPTH; i++) w.push_back($urandom);
    build(0, w, 1'b0);
    run(0);
    chk("t4_nwr", wa_log.size(), DEPTH);
    foreach (wa_log[i]) chk("t4_wa", wa_log[i], i);
    chk("t4_done", done_n, 1);

    // reset mid-frame after two payload bytes
    clear_logs();
    step(1'b1, SYNC, 1'b0, a);
    step(1'b1, 8'h01, 1'b0, a);
    step(1'b1, 8'h11, 1'b0, a);
    step(1'b1, 8'h22, 1'b0, a);
    step(1'b0, 8'h00, 1'b1, a);
    w = '{32'hCAFEF00D};
    build(1, w, 1'b0);
    run(0);
    chk("t5_nwr", wa_log.size(), 1);
    if (wa_log.size() > 0) chk("t5_wa", wa_log[0], 0);

    // trailing byte after frame is an idle byte
    clear_logs();
    w = '{32'h11223344};
    build(1, w, 1'b0);
    s.push_back(8'h5A);
    run(0);
    chk("t6_nwr", wd_log.size(), 1);
    if (wd_log.size() > 0) chk("t6_wd", wd_log[0], 32'h11223344);
    chk("t6_done", done_n, 1);

    // random frames with noise, truncated counts and gaps
    for (int f = 0; f < 10; f++) begin
      logic [7:0] nz;
      nz = 8'($urandom);
      if (nz == SYNC) nz = 8'h00;
      s.push_back(nz);
      n = $urandom_range(1, 4);
      if (f % 4 == 3) n += DEPTH;
      w.delete();
      for (int i = 0; i < n % DEPTH; i++) w.push_back($urandom);
      build(n, w, ($urandom_range(0, 1) == 1));
      run(2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
